// File: rtl/mcb_cmd_if.sv
// mcb_cmd_if: requester, FIFO-status and controller command-port signals of the command arbiter
interface mcb_cmd_if #(
  parameter int ADDR_W = 30,
  parameter int BL_W   = 6,
  parameter int CNT_W  = 7
);
  logic              calib_done;
  logic              cmd_full;
  logic              w_req;
  logic [BL_W-1:0]   w_bl;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ack;
  logic [CNT_W-1:0]  wr_count;
  logic              r_req;
  logic [BL_W-1:0]   r_bl;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ack;
  logic [CNT_W-1:0]  rd_count;
  logic              r_data_push;
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [BL_W-1:0]   cmd_bl;
  logic [ADDR_W-1:0] cmd_addr;
  logic              busy;
  logic              rd_underflow;
  modport slave (
    input  calib_done, cmd_full, w_req, w_bl, w_addr, wr_count,
           r_req, r_bl, r_addr, rd_count, r_data_push,
    output w_ack, r_ack, cmd_en, cmd_instr, cmd_bl, cmd_addr, busy, rd_underflow
  );
  modport master (
    output calib_done, cmd_full, w_req, w_bl, w_addr, wr_count,
           r_req, r_bl, r_addr, rd_count, r_data_push,
    input  w_ack, r_ack, cmd_en, cmd_instr, cmd_bl, cmd_addr, busy, rd_underflow
  );
endinterface

// File: rtl/mcb_cmd_arbiter.sv
// mcb_cmd_arbiter: shares the DDR command port between write and read requesters with FIFO gating
module mcb_cmd_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int BL_W       = 6,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 7,
  parameter int WR_URGENT  = 48
) (
  input logic     clk,
  input logic     reset_n,
  mcb_cmd_if.slave bus
);
  localparam int SW = CNT_W + 2;
  localparam int PW = CNT_W + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_n;
  logic last_rd;
  logic [PW-1:0] rd_pending;
  logic w_elig, r_elig, can, gw, gr, pop;
  always_comb begin
    w_elig  = bus.w_req && SW'(bus.wr_count) >= SW'(bus.w_bl) + SW'(1);
    r_elig  = bus.r_req && SW'(bus.rd_count) + SW'(rd_pending) + SW'(bus.r_bl) + SW'(1) <= SW'(FIFO_DEPTH);
    can     = bus.calib_done && !bus.cmd_full && state == IDLE;
    gw      = can && w_elig && (!r_elig || bus.wr_count >= CNT_W'(WR_URGENT) || last_rd);
    gr      = can && r_elig && !gw;
    // a push coinciding with a new read grant is absorbed by the new burst, not an underflow
    pop     = bus.r_data_push && (rd_pending != '0 || gr);
    state_n = state == IDLE ? ((gw || gr) ? ISSUE : IDLE) : state == ISSUE ? HOLD : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      last_rd          <= 1'b1;
      rd_pending       <= '0;
      bus.cmd_en       <= 1'b0;
      bus.w_ack        <= 1'b0;
      bus.r_ack        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.rd_underflow <= 1'b0;
      bus.cmd_instr    <= '0;
      bus.cmd_bl       <= '0;
      bus.cmd_addr     <= '0;
    end else begin
      state      <= state_n;
      bus.cmd_en <= gw || gr;
      bus.w_ack  <= gw;
      bus.r_ack  <= gr;
      bus.busy   <= state_n != IDLE;
      rd_pending <= rd_pending + (gr ? PW'(bus.r_bl) + PW'(1) : '0) - PW'(pop);
      if (bus.r_data_push && !pop) bus.rd_underflow <= 1'b1;
      if (gw || gr) begin
        bus.cmd_instr <= gr ? 3'b001 : 3'b000;
        bus.cmd_bl    <= gr ? bus.r_bl : bus.w_bl;
        bus.cmd_addr  <= gr ? bus.r_addr : bus.w_addr;
        last_rd       <= gr;
      end
    end
  end
endmodule
